// File: rtl/mmio_event_injector.sv
// Turns debounced push-button presses into single-word RAM writes, slipped in on idle processor cycles.
// Write lands DEBOUNCE_CYCLES+3 edges after a clean press; processor accesses always win the port.
module mmio_event_injector #(
   parameter int NUM_CH          = 4,
   parameter int ADDR_W          = 12,
   parameter int DATA_W          = 32,
   parameter int BASE_ADDR       = 205,
   parameter int EVENT_DATA      = 1,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int REPEAT_DELAY    = 0,
   parameter int REPEAT_PERIOD   = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [NUM_CH-1:0] btn,
   input  logic              cpu_access,
   input  logic              cpu_wen,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_din,
   output logic              ram_wen,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   output logic [NUM_CH-1:0] pending,
   output logic [15:0]       drop_count
);

   localparam int CW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int HW   = $clog2(RMAX + 1);
   localparam int IW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH-1:0] sync1, sync2, db, db_prev, rep_phase, rep_fire, evt;
   logic [CW-1:0]     db_cnt   [NUM_CH];
   logic [HW-1:0]     hold_cnt [NUM_CH];

   logic              inj_valid;
   logic [IW-1:0]     inj_ch, last_granted, win_ch, cand;
   logic              win_vld, grant;
   logic [4:0]        drop_n;
   logic [16:0]       drop_sum;

   // Synchroniser, debouncer and hold-to-repeat timer per channel
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1     <= '0;
         sync2     <= '0;
         db        <= '0;
         db_prev   <= '0;
         rep_phase <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            db_cnt[i]   <= '0;
            hold_cnt[i] <= '0;
         end
      end else begin
         sync1   <= btn;
         sync2   <= sync1;
         db_prev <= db;
         for (int i = 0; i < NUM_CH; i++) begin
            if (sync2[i] == db[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
               db[i]     <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + CW'(1);
            end

            if (!db[i]) begin
               hold_cnt[i]  <= '0;
               rep_phase[i] <= 1'b0;
            end else if (rep_fire[i]) begin
               hold_cnt[i]  <= HW'(1);
               rep_phase[i] <= 1'b1;
            end else if (REPEAT_DELAY != 0) begin
               hold_cnt[i] <= hold_cnt[i] + HW'(1);
            end
         end
      end
   end

   // hold_cnt counts up to the initial delay, then restarts for each repeat period
   always_comb begin
      rep_fire = '0;
      evt      = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (REPEAT_DELAY != 0 && db[i]) begin
            rep_fire[i] = rep_phase[i] ? (hold_cnt[i] == HW'(REPEAT_PERIOD))
                                       : (hold_cnt[i] == HW'(REPEAT_DELAY));
         end
         evt[i] = (db[i] & ~db_prev[i]) | rep_fire[i];
      end
   end

   // Round-robin search starting just after the last granted channel
   always_comb begin
      win_vld = 1'b0;
      win_ch  = '0;
      cand    = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         cand = IW'((int'(last_granted) + k) % NUM_CH);
         if (!win_vld && pending[cand]) begin
            win_vld = 1'b1;
            win_ch  = cand;
         end
      end
   end

   assign grant = !inj_valid && win_vld;

   always_comb begin
      drop_n = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (evt[i] && pending[i] && !(grant && win_ch == IW'(i))) begin
            drop_n = drop_n + 5'd1;
         end
      end
   end

   assign drop_sum = {1'b0, drop_count} + 17'(drop_n);

   always_ff @(posedge clock) begin
      if (reset) begin
         pending      <= '0;
         drop_count   <= '0;
         inj_valid    <= 1'b0;
         inj_ch       <= '0;
         last_granted <= IW'(NUM_CH - 1);
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (evt[i]) begin
               pending[i] <= 1'b1;
            end else if (grant && win_ch == IW'(i)) begin
               pending[i] <= 1'b0;
            end
         end
         drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

         if (grant) begin
            inj_valid    <= 1'b1;
            inj_ch       <= win_ch;
            last_granted <= win_ch;
         end else if (inj_valid && !cpu_access) begin
            inj_valid <= 1'b0;
         end
      end
   end

   // Processor always owns the port when it asks; injection only fills idle cycles
   always_comb begin
      ram_wen  = cpu_wen;
      ram_addr = cpu_addr;
      ram_din  = cpu_din;
      if (!cpu_access) begin
         if (inj_valid) begin
            ram_wen  = 1'b1;
            ram_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(inj_ch);
            ram_din  = DATA_W'(EVENT_DATA);
         end else begin
            ram_wen = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mmio_event_injector.sv
// Directed scenarios plus a long randomized run, all compared cycle by cycle against a time-based reference model.
module tb_mmio_event_injector;

   localparam int N    = 4;
   localparam int AW   = 12;
   localparam int DW   = 32;
   localparam int BASE = 205;
   localparam int EVD  = 1;
   localparam int DB   = 4;
   localparam int RD   = 10;
   localparam int RP   = 5;

   logic          clock = 1'b0;
   logic          reset;
   logic [N-1:0]  btn;
   logic          cpu_access, cpu_wen;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_din;
   logic          ram_wen;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic [N-1:0]  pending;
   logic [15:0]   drop_count;

   always #5 clock = ~clock;

   mmio_event_injector #(
      .NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(BASE), .EVENT_DATA(EVD),
      .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut (
      .clock(clock), .reset(reset), .btn(btn),
      .cpu_access(cpu_access), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
      .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_din(ram_din),
      .pending(pending), .drop_count(drop_count)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model: levels, sample history, time of last debounced rise, event queue flags
   bit m_s1 [N];
   bit m_s2 [N];
   bit m_db [N];
   bit m_hist [N][DB];
   int m_rise [N];
   bit m_pend [N];
   bit m_iv;
   int m_ich, m_last, m_drop;

   int wr_cyc [$];
   int wr_addr [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < N; i++) begin
         m_s1[i] = 0; m_s2[i] = 0; m_db[i] = 0; m_rise[i] = 0; m_pend[i] = 0;
         for (int k = 0; k < DB; k++) m_hist[i][k] = 0;
      end
      m_iv = 0; m_ich = 0; m_last = N - 1; m_drop = 0;
   endfunction

   // Event in cycle c: first cycle of a debounced high, then at hold age RD, RD+RP, RD+2RP, ...
   function automatic bit m_event(int i, int c);
      int age;
      age = c - m_rise[i];
      if (!m_db[i]) return 0;
      if (age == 0) return 1;
      return (RD > 0) && (age >= RD) && ((age - RD) % RP == 0);
   endfunction

   function automatic void model_edge(int c);
      bit ev [N];
      bit all_diff;
      int gw, j;
      if (reset) begin
         model_reset();
         return;
      end
      for (int i = 0; i < N; i++) ev[i] = m_event(i, c);
      gw = -1;
      if (!m_iv) begin
         for (int k = 1; k <= N; k++) begin
            j = (m_last + k) % N;
            if (gw < 0 && m_pend[j]) gw = j;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (ev[i]) begin
            if (m_pend[i] && i != gw && m_drop < 65535) m_drop++;
            m_pend[i] = 1;
         end else if (i == gw) begin
            m_pend[i] = 0;
         end
      end
      if (gw >= 0) begin
         m_iv = 1; m_ich = gw; m_last = gw;
      end else if (m_iv && !cpu_access) begin
         m_iv = 0;
      end
      for (int i = 0; i < N; i++) begin
         for (int k = DB - 1; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
         m_hist[i][0] = m_s2[i];
         all_diff = 1;
         for (int k = 0; k < DB; k++) if (m_hist[i][k] == m_db[i]) all_diff = 0;
         if (all_diff) begin
            m_db[i] = !m_db[i];
            if (m_db[i]) m_rise[i] = c + 1;
         end
         m_s2[i] = m_s1[i];
         m_s1[i] = btn[i];
      end
   endfunction

   task automatic tick();
      logic          e_wen;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_din;
      logic [N-1:0]  e_pend;
      @(negedge clock);
      e_wen = cpu_wen; e_addr = cpu_addr; e_din = cpu_din;
      if (!cpu_access) begin
         e_wen = m_iv;
         if (m_iv) begin
            e_addr = AW'((BASE + m_ich) % (1 << AW));
            e_din  = DW'(EVD);
         end
      end
      for (int i = 0; i < N; i++) e_pend[i] = m_pend[i];
      check("ram_wen",    32'(ram_wen),    32'(e_wen));
      check("ram_addr",   32'(ram_addr),   32'(e_addr));
      check("ram_din",    32'(ram_din),    32'(e_din));
      check("pending",    32'(pending),    32'(e_pend));
      check("drop_count", 32'(drop_count), 32'(m_drop));
      if (ram_wen === 1'b1 && cpu_access === 1'b0) begin
         wr_cyc.push_back(cyc);
         wr_addr.push_back(int'(ram_addr));
      end
      @(posedge clock);
      model_edge(cyc);
      cyc++;
      #1;
   endtask

   task automatic do_reset();
      reset = 1; btn = '0; cpu_access = 0; cpu_wen = 0; cpu_addr = 12'h123; cpu_din = '0;
      tick();
      tick();
      reset = 0;
      wr_cyc.delete();
      wr_addr.delete();
   endtask

   function automatic int wc(int n);
      return (n < wr_cyc.size()) ? wr_cyc[n] : -1;
   endfunction

   function automatic int wa(int n);
      return (n < wr_addr.size()) ? wr_addr[n] : -1;
   endfunction

   initial begin
      int k;
      reset = 1; btn = '0; cpu_access = 0; cpu_wen = 0; cpu_addr = '0; cpu_din = '0;
      @(posedge clock);
      model_reset();
      cyc = 1;
      #1;

      // Reset state: nothing pending, port passes the processor through
      do_reset();
      check("rst_pending", 32'(pending), 32'd0);
      check("rst_drop",    32'(drop_count), 32'd0);
      check("rst_wen",     32'(ram_wen), 32'd0);
      check("rst_addr",    32'(ram_addr), 32'h123);

      // Single clean press: one write to BASE, DB+4 cycles after btn changes
      do_reset();
      k = cyc; btn[0] = 1;
      repeat (8) tick();
      btn[0] = 0;
      repeat (20) tick();
      check("single_count", wr_cyc.size(), 1);
      check("single_addr",  wa(0), 205);
      check("single_cycle", wc(0), k + 8);

      // Bounce shorter than the debounce window, then settle high
      do_reset();
      for (int b = 0; b < 4; b++) begin
         btn[1] = (b % 2 == 0);
         repeat (2) tick();
      end
      btn[1] = 1;
      repeat (8) tick();
      btn[1] = 0;
      repeat (20) tick();
      check("bounce_count", wr_cyc.size(), 1);
      check("bounce_addr",  wa(0), 206);

      // Processor keeps the port for 20 cycles; injection waits for the first free cycle
      do_reset();
      k = cyc;
      cpu_access = 1; cpu_wen = 1; cpu_addr = 12'd50; cpu_din = $urandom;
      btn[0] = 1;
      for (int i = 0; i < 20; i++) begin
         if (i == 8) btn[0] = 0;
         tick();
         check("prio_wen",  32'(ram_wen), 32'd1);
         check("prio_addr", 32'(ram_addr), 32'd50);
      end
      cpu_access = 0; cpu_wen = 0;
      repeat (10) tick();
      check("prio_count", wr_cyc.size(), 1);
      check("prio_addr",  wa(0), 205);
      check("prio_cycle", wc(0), k + 20);

      // Simultaneous presses on channels 0 and 2: served in round-robin order, two cycles apart
      do_reset();
      k = cyc; btn = 4'b0101;
      repeat (8) tick();
      btn = '0;
      repeat (20) tick();
      check("rr_count", wr_cyc.size(), 2);
      check("rr_addr0", wa(0), 205);
      check("rr_addr1", wa(1), 207);
      check("rr_cyc0",  wc(0), k + 8);
      check("rr_cyc1",  wc(1), k + 10);
      check("rr_pending", 32'(pending), 32'd0);

      // Coalescing: channel 0 occupies the injection slot, channel 3 fires three times while stalled
      do_reset();
      cpu_access = 1; cpu_wen = 0;
      for (int p = 0; p < 3; p++) begin
         btn[3] = 1;
         if (p == 0) btn[0] = 1;
         repeat (8) tick();
         btn = '0;
         repeat (8) tick();
      end
      check("coal_pending", 32'(pending), 32'b1000);
      check("coal_drop",    32'(drop_count), 32'd2);
      cpu_access = 0;
      repeat (10) tick();
      check("coal_count", wr_cyc.size(), 2);
      check("coal_addr0", wa(0), 205);
      check("coal_addr1", wa(1), 208);

      // Hold-to-repeat: rise, then +10, +15, +20, +25, +30 while the level stays high
      do_reset();
      k = cyc; btn[0] = 1;
      repeat (34) tick();
      btn[0] = 0;
      repeat (20) tick();
      check("rep_count", wr_cyc.size(), 6);
      check("rep_first", wc(0), k + 8);
      check("rep_2nd",   wc(1), k + 18);
      check("rep_3rd",   wc(2), k + 23);
      check("rep_last",  wc(5), k + 38);

      // Reset during the write cycle cancels the write
      do_reset();
      btn[0] = 1;
      repeat (8) tick();
      check("midrst_pre_wen", 32'(ram_wen), 32'd1);
      reset = 1; btn = '0;
      tick();
      check("midrst_wen",     32'(ram_wen), 32'd0);
      check("midrst_pending", 32'(pending), 32'd0);
      reset = 0;
      repeat (20) tick();

      // Randomized traffic: slow button toggles, bursty processor, rare resets
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) if ($urandom_range(0, 11) == 0) btn[i] = ~btn[i];
         if ($urandom_range(0, 7) == 0) cpu_access = ~cpu_access;
         cpu_wen  = 1'($urandom);
         cpu_addr = AW'($urandom);
         cpu_din  = $urandom;
         reset    = ($urandom_range(0, 999) == 0);
         tick();
      end
      reset = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mmio_event_injector.md
# mmio_event_injector

Converts NUM_CH raw push-button inputs into single-word memory-mapped writes into the shared data RAM. Each channel is synchronised and debounced, then rise-edge detected, with optional hold-to-repeat. Resulting events are queued as per-channel pending flags and granted round-robin. Each write is injected only on cycles when the processor is not using the RAM port, so processor loads and stores are never corrupted or dropped. The block sits between the processor's dmem port and the RAM, replacing the ad-hoc edge-detect-and-override write logic at the top level.

## Interface
- NUM_CH, 4: number of button channels (1..16).
- ADDR_W, 12: RAM address width.
- DATA_W, 32: RAM data width.
- BASE_ADDR, 205: channel i writes to address BASE_ADDR+i (modulo 2^ADDR_W).
- EVENT_DATA, 1: value written for each event.
- DEBOUNCE_CYCLES, 16: consecutive stable synchronised samples required to accept a new level (>=1).
- REPEAT_DELAY, 0: cycles of continuous debounced hold before the first repeat event; 0 disables auto-repeat.
- REPEAT_PERIOD, 8: cycles between subsequent repeat events (>=1).

Ports:
- clock  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- btn  in  NUM_CH  raw asynchronous button levels, active-high.
- cpu_access  in  1  processor owns the RAM port this cycle (load or store).
- cpu_wen  in  1  processor write enable.
- cpu_addr  in  ADDR_W  processor address.
- cpu_din  in  DATA_W  processor write data.
- ram_wen  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_din  out  DATA_W  RAM write data.
- pending  out  NUM_CH  per-channel event waiting for the port.
- drop_count  out  16  saturating count of coalesced (lost) events.

## Operation
- Per channel, in order: 2-flop synchroniser -> debouncer -> edge/repeat generator -> pending flag.
- **Debouncer.**
  - Holds a debounced level `db` and a counter.
  - When the synchroniser output equals `db`, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 and the sample still differs, `db` takes the sample and the counter clears.
- **Event generation.** An event fires on any cycle where either of these holds:
  - `db` rises from 0 to 1.
  - REPEAT_DELAY>0, `db` is held at 1, and the hold counter reaches REPEAT_DELAY, then every REPEAT_PERIOD cycles after that.
  - A fall of `db` clears the hold counter.
- **Pending flags.**
  - An event sets pending[i].
  - An event arriving while pending[i] is already 1 is coalesced: pending stays 1 and drop_count increments, saturating at 16'hFFFF.
  - An event arriving on the same cycle that pending[i] is granted re-sets pending[i] and is not counted as a drop.
- **Injection register** (inj_valid, inj_ch).
  - When inj_valid=0 and pending!=0, the next posedge loads the round-robin winner. The search starts at channel (last_granted+1) mod NUM_CH, with last_granted=NUM_CH-1 after reset.
  - The same posedge clears pending for the winner and sets inj_valid=1.
- **Port mux** (combinational).
  - If cpu_access=1: ram_* = cpu_wen/cpu_addr/cpu_din.
  - Else if inj_valid=1: ram_wen=1, ram_addr=BASE_ADDR+inj_ch, ram_din=EVENT_DATA.
  - Else: ram_wen=0, ram_addr=cpu_addr, ram_din=cpu_din.
- inj_valid clears at the posedge ending a cycle in which cpu_access=0, because the write has completed. A new winner may load on the following posedge.

## Timing
- **Reset values.**
  - Synchronisers and `db` = 0; all counters = 0.
  - pending = 0, inj_valid = 0, drop_count = 0, last_granted = NUM_CH-1.
  - ram_* follows the mux with inj_valid=0, so it passes the processor's signals through.
- **Latency.**
  - A clean rise of btn[i] is sampled at edge E0.
  - `db` rises DEBOUNCE_CYCLES+1 edges later; pending[i] sets on the following edge.
  - inj_valid sets one edge after that.
  - ram_wen asserts in that cycle if cpu_access=0.
  - Total = DEBOUNCE_CYCLES+3 edges from E0 to the write cycle, with an idle port.
- **Injected write throughput.** At most one every 2 cycles (load cycle, then issue cycle).
- **Glitches.** A glitch shorter than DEBOUNCE_CYCLES synchronised samples produces no event.
- **Processor hold-off.** cpu_access held high stalls injection indefinitely. Events keep accumulating in pending and drops are counted.
- **Reset mid-operation.** Reset asserted while an injection is in flight drops that injection. No partial write occurs, because ram_wen is combinational from inj_valid, which clears on the reset edge.

## Test plan
- **Single press.** DEBOUNCE_CYCLES=4, btn[0] rises and holds, cpu_access=0 -> exactly one write: ram_wen=1, ram_addr=205, ram_din=1, 7 edges after the first sample; no further writes.
- **Bounce.** btn[1] toggles 1,0,1,0 with 2-cycle widths, then settles at 1 -> exactly one write, to address 206.
- **Processor priority.** cpu_access=1, cpu_wen=1, cpu_addr=50 held for 20 cycles while btn[0] is pressed -> all 20 cycles write to address 50; the injected write to 205 occurs in the first cycle with cpu_access=0.
- **Round-robin with simultaneous presses.** btn[0] and btn[2] press on the same cycle -> writes to 205 then 207, 2 cycles apart; pending returns to 0.
- **Coalescing.** cpu_access held high, btn[3] pressed and released 3 times -> pending[3]=1, drop_count=2, and a single write to 208 occurs once the port frees.
- **Auto-repeat.** REPEAT_DELAY=10, REPEAT_PERIOD=5, btn[0] held for 30 cycles after debounce -> writes from the rise event, +10, +15, +20, +25; no writes after release.
